// File: rtl/axis_user_mux_pkg.sv
// Shared data-link types: link status, register stage types, tuser tag bits
// and the transmit mux state encoding.
package pcie_datalink_pkg;

   typedef enum logic [1:0] {
      DL_INACTIVE = 2'd0,
      DL_INIT     = 2'd1,
      DL_ACTIVE   = 2'd2
   } pcie_dl_status_e;

   // axis_register REG_TYPE selections
   localparam int unsigned Bypass     = 0;
   localparam int unsigned SkidBuffer = 2;

   // tuser tag bit positions, shared with the receive demux
   localparam int unsigned UserIsTlp  = 1;
   localparam int unsigned UserIsDllp = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TLP  = 2'd1,
      ST_DLLP = 2'd2
   } mux_st_e;

endpackage

// File: rtl/axis_user_mux_if.sv
// AXI-Stream bundle with tkeep/tlast/tuser.
interface axis_user_mux_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned USER_WIDTH = 2
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_user_mux_reg.sv
// AXI-Stream register slice. SkidBuffer gives a registered tready, one cycle
// of latency and full throughput; any other REG_TYPE is a plain wire.
module axis_register
   import pcie_datalink_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int unsigned USER_WIDTH  = 2,
   parameter int unsigned REG_TYPE    = SkidBuffer,
   parameter bit          KEEP_ENABLE = 1'b1,
   parameter bit          LAST_ENABLE = 1'b1,
   parameter bit          USER_ENABLE = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_s_tdata,
   input  logic [KEEP_WIDTH-1:0] i_s_tkeep,
   input  logic                  i_s_tvalid,
   input  logic                  i_s_tlast,
   input  logic [USER_WIDTH-1:0] i_s_tuser,
   output logic                  o_s_tready,
   output logic [DATA_WIDTH-1:0] o_m_tdata,
   output logic [KEEP_WIDTH-1:0] o_m_tkeep,
   output logic                  o_m_tvalid,
   output logic                  o_m_tlast,
   output logic [USER_WIDTH-1:0] o_m_tuser,
   input  logic                  i_m_tready
);
   localparam int unsigned BW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

   logic [BW-1:0]         w_s_bus;
   logic [BW-1:0]         w_m_bus;
   logic [DATA_WIDTH-1:0] w_m_tdata;
   logic [KEEP_WIDTH-1:0] w_m_tkeep;
   logic                  w_m_tlast;
   logic [USER_WIDTH-1:0] w_m_tuser;

   assign w_s_bus = {i_s_tdata, i_s_tkeep, i_s_tlast, i_s_tuser};

   generate
      if (REG_TYPE == SkidBuffer) begin : g_skid
         logic          r_s_ready, r_m_valid, r_t_valid;
         logic [BW-1:0] r_m_bus, r_t_bus;
         logic          w_ready_early, w_m_valid_nxt, w_t_valid_nxt;
         logic          w_in_to_out, w_in_to_tmp, w_tmp_to_out;

         // Ready for next cycle: output drains, or the skid slot is free and
         // the output register will not fill up this cycle.
         assign w_ready_early = i_m_tready || (!r_t_valid && (!r_m_valid || !i_s_tvalid));

         // Decide where an incoming beat lands and whether the skid slot drains.
         always_comb begin
            w_m_valid_nxt = r_m_valid;
            w_t_valid_nxt = r_t_valid;
            w_in_to_out   = 1'b0;
            w_in_to_tmp   = 1'b0;
            w_tmp_to_out  = 1'b0;
            if (r_s_ready) begin
               if (i_m_tready || !r_m_valid) begin
                  w_m_valid_nxt = i_s_tvalid;
                  w_in_to_out   = 1'b1;
               end else begin
                  w_t_valid_nxt = i_s_tvalid;
                  w_in_to_tmp   = 1'b1;
               end
            end else if (i_m_tready) begin
               w_m_valid_nxt = r_t_valid;
               w_t_valid_nxt = 1'b0;
               w_tmp_to_out  = 1'b1;
            end
         end

         // Control and data registers; payload needs no reset.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_s_ready <= 1'b0;
               r_m_valid <= 1'b0;
               r_t_valid <= 1'b0;
            end else begin
               r_s_ready <= w_ready_early;
               r_m_valid <= w_m_valid_nxt;
               r_t_valid <= w_t_valid_nxt;
            end
            if (w_in_to_out)       r_m_bus <= w_s_bus;
            else if (w_tmp_to_out) r_m_bus <= r_t_bus;
            if (w_in_to_tmp)       r_t_bus <= w_s_bus;
         end

         assign o_s_tready = r_s_ready;
         assign o_m_tvalid = r_m_valid;
         assign w_m_bus    = r_m_bus;
      end else begin : g_bypass
         assign o_s_tready = i_m_tready;
         assign o_m_tvalid = i_s_tvalid;
         assign w_m_bus    = w_s_bus;
      end
   endgenerate

   assign {w_m_tdata, w_m_tkeep, w_m_tlast, w_m_tuser} = w_m_bus;
   assign o_m_tdata = w_m_tdata;
   assign o_m_tkeep = KEEP_ENABLE ? w_m_tkeep : '1;
   assign o_m_tlast = LAST_ENABLE ? w_m_tlast : 1'b1;
   assign o_m_tuser = USER_ENABLE ? w_m_tuser : '0;
endmodule

// File: rtl/axis_user_mux.sv
// Transmit mux: merges TLP and DLLP streams into one tagged stream.
// Packet-atomic arbitration, DLLP priority with a bounded DLLP streak
// while a TLP waits; TLP grants only while the link is DL_ACTIVE.
module axis_user_mux
   import pcie_datalink_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned USER_WIDTH     = 2,
   parameter int unsigned DLLP_BURST_MAX = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  pcie_dl_status_e link_status_i,
   axis_user_mux_if.slave  s_tlp_axis,
   axis_user_mux_if.slave  s_dllp_axis,
   axis_user_mux_if.master m_axis
);
   localparam int unsigned         SW         = $clog2(DLLP_BURST_MAX + 1);
   localparam logic [SW-1:0]       STREAK_MAX = SW'(DLLP_BURST_MAX);

   mux_st_e               r_state, w_state_nxt;
   logic [SW-1:0]         r_streak;
   logic                  w_tlp_ok, w_sel_tlp, w_sel_dllp, w_reg_ready;
   logic                  w_tlp_acc, w_dllp_acc;
   logic [DATA_WIDTH-1:0] w_mux_data;
   logic [KEEP_WIDTH-1:0] w_mux_keep;
   logic                  w_mux_valid, w_mux_last;
   logic [USER_WIDTH-1:0] w_mux_user;

   assign w_tlp_ok   = s_tlp_axis.tvalid && (link_status_i == DL_ACTIVE);
   assign w_tlp_acc  = s_tlp_axis.tvalid && s_tlp_axis.tready;
   assign w_dllp_acc = s_dllp_axis.tvalid && s_dllp_axis.tready;

   assign s_tlp_axis.tready  = w_sel_tlp && w_reg_ready;
   assign s_dllp_axis.tready = w_sel_dllp && w_reg_ready;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Grant selection and next state; the grant cycle already carries a beat,
   // so a single-beat packet returns straight to idle.
   always_comb begin
      w_sel_tlp   = 1'b0;
      w_sel_dllp  = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (s_dllp_axis.tvalid && !(w_tlp_ok && r_streak == STREAK_MAX)) w_sel_dllp = 1'b1;
            else if (w_tlp_ok)                                               w_sel_tlp  = 1'b1;
         end
         ST_TLP:  w_sel_tlp  = 1'b1;
         ST_DLLP: w_sel_dllp = 1'b1;
         default: ;
      endcase
      if (w_sel_tlp)  w_state_nxt = (w_tlp_acc && s_tlp_axis.tlast)   ? ST_IDLE : ST_TLP;
      if (w_sel_dllp) w_state_nxt = (w_dllp_acc && s_dllp_axis.tlast) ? ST_IDLE : ST_DLLP;
   end

   // Count completed DLLPs while a TLP is waiting.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_streak <= '0;
      else if (r_state == ST_IDLE && (w_sel_tlp || !s_tlp_axis.tvalid))
         r_streak <= '0;
      else if (w_dllp_acc && s_dllp_axis.tlast && s_tlp_axis.tvalid && r_streak != STREAK_MAX)
         r_streak <= r_streak + 1'b1;
   end

   // Route the granted input and stamp the type tag bits.
   always_comb begin
      w_mux_valid = 1'b0;
      w_mux_data  = s_tlp_axis.tdata;
      w_mux_keep  = s_tlp_axis.tkeep;
      w_mux_last  = s_tlp_axis.tlast;
      w_mux_user  = s_tlp_axis.tuser;
      if (w_sel_dllp) begin
         w_mux_valid = s_dllp_axis.tvalid;
         w_mux_data  = s_dllp_axis.tdata;
         w_mux_keep  = s_dllp_axis.tkeep;
         w_mux_last  = s_dllp_axis.tlast;
         w_mux_user  = s_dllp_axis.tuser;
      end else if (w_sel_tlp) begin
         w_mux_valid = s_tlp_axis.tvalid;
      end
      w_mux_user[UserIsTlp]  = w_sel_tlp;
      w_mux_user[UserIsDllp] = w_sel_dllp;
   end

   axis_register #(
      .DATA_WIDTH  (DATA_WIDTH),
      .KEEP_WIDTH  (KEEP_WIDTH),
      .USER_WIDTH  (USER_WIDTH),
      .REG_TYPE    (SkidBuffer),
      .KEEP_ENABLE (1'b1),
      .LAST_ENABLE (1'b1),
      .USER_ENABLE (1'b1)
   ) u_out_reg (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_s_tdata  (w_mux_data),
      .i_s_tkeep  (w_mux_keep),
      .i_s_tvalid (w_mux_valid),
      .i_s_tlast  (w_mux_last),
      .i_s_tuser  (w_mux_user),
      .o_s_tready (w_reg_ready),
      .o_m_tdata  (m_axis.tdata),
      .o_m_tkeep  (m_axis.tkeep),
      .o_m_tvalid (m_axis.tvalid),
      .o_m_tlast  (m_axis.tlast),
      .o_m_tuser  (m_axis.tuser),
      .i_m_tready (m_axis.tready)
   );
endmodule

// File: tb/tb_axis_user_mux.sv
// Directed bench for axis_user_mux: arbitration order, tagging, link gating,
// backpressure and mid-packet reset.
module tb_axis_user_mux;
   import pcie_datalink_pkg::*;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  u;
      logic        l;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   pcie_dl_status_e link = DL_ACTIVE;

   axis_user_mux_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(2)) tlp_if ();
   axis_user_mux_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(2)) dllp_if ();
   axis_user_mux_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(2)) m_if ();

   axis_user_mux #(
      .DATA_WIDTH     (32),
      .KEEP_WIDTH     (4),
      .USER_WIDTH     (2),
      .DLLP_BURST_MAX (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .link_status_i (link),
      .s_tlp_axis    (tlp_if),
      .s_dllp_axis   (dllp_if),
      .m_axis        (m_if)
   );

   always #5 clk = ~clk;

   beat_t tlp_q[$], dllp_q[$], out_q[$], exp_q[$];
   int    out_cyc[$], in_cyc[$];
   int    cyc = 0;
   int    tlp_acc = 0, dllp_acc = 0;
   bit    tlp_ready_seen = 1'b0;
   int    n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      tlp_if.tvalid  = (tlp_q.size() != 0);
      dllp_if.tvalid = (dllp_q.size() != 0);
      if (tlp_q.size() != 0) begin
         tlp_if.tdata = tlp_q[0].d; tlp_if.tuser = tlp_q[0].u; tlp_if.tlast = tlp_q[0].l;
      end
      if (dllp_q.size() != 0) begin
         dllp_if.tdata = dllp_q[0].d; dllp_if.tuser = dllp_q[0].u; dllp_if.tlast = dllp_q[0].l;
      end
   endtask

   // One clock: observe handshakes at the falling edge, update inputs after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (m_if.tvalid && m_if.tready) begin
         out_q.push_back('{d: m_if.tdata, u: m_if.tuser, l: m_if.tlast});
         out_cyc.push_back(cyc);
      end
      if (tlp_if.tready) tlp_ready_seen = 1'b1;
      if (tlp_if.tvalid && tlp_if.tready) begin
         void'(tlp_q.pop_front()); tlp_acc++; in_cyc.push_back(cyc);
      end
      if (dllp_if.tvalid && dllp_if.tready) begin
         void'(dllp_q.pop_front()); dllp_acc++; in_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ptlp(input logic [31:0] dd, input logic [1:0] uu, input logic ll);
      tlp_q.push_back('{d: dd, u: uu, l: ll});
   endtask

   task automatic pdllp(input logic [31:0] dd, input logic [1:0] uu, input logic ll);
      dllp_q.push_back('{d: dd, u: uu, l: ll});
   endtask

   task automatic ex(input logic [31:0] dd, input logic [1:0] uu, input logic ll);
      exp_q.push_back('{d: dd, u: uu, l: ll});
   endtask

   task automatic new_test();
      out_q.delete(); exp_q.delete(); out_cyc.delete(); in_cyc.delete();
      tlp_acc = 0; dllp_acc = 0; tlp_ready_seen = 1'b0;
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < out_q.size()) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(out_q[i].d), 64'(exp_q[i].d));
            chk($sformatf("%s_user_last%0d", tag, i), 64'({out_q[i].u, out_q[i].l}),
                64'({exp_q[i].u, exp_q[i].l}));
         end
      end
   endtask

   initial begin
      int snap;
      tlp_if.tkeep = 4'hF; dllp_if.tkeep = 4'hF;
      tlp_if.tdata = '0; tlp_if.tuser = '0; tlp_if.tlast = 1'b0;
      dllp_if.tdata = '0; dllp_if.tuser = '0; dllp_if.tlast = 1'b0;
      m_if.tready = 1'b1;
      drive();

      // Reset state
      run(2);
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
      chk("rst_tlp_tready", 64'(tlp_if.tready), 64'(0));
      chk("rst_dllp_tready", 64'(dllp_if.tready), 64'(0));
      chk("rst_state", 64'(dut.r_state), 64'(ST_IDLE));
      rst = 1'b0;

      // TLP alone; source tag bits deliberately wrong to prove stamping
      new_test();
      ptlp(32'h11, 2'b01, 1'b0); ptlp(32'h22, 2'b01, 1'b0); ptlp(32'h33, 2'b01, 1'b1);
      drive();
      run(10);
      ex(32'h11, 2'b10, 1'b0); ex(32'h22, 2'b10, 1'b0); ex(32'h33, 2'b10, 1'b1);
      cmp_stream("tlp_alone");
      if (out_cyc.size() > 0 && in_cyc.size() > 0)
         chk("tlp_alone_latency", 64'(out_cyc[0] - in_cyc[0]), 64'(1));
      chk("tlp_alone_keep", 64'(m_if.tkeep), 64'(4'hF));

      // Simultaneous DLLP + TLP: DLLP first, no interleave, no bubble
      new_test();
      pdllp(32'hD1, 2'b10, 1'b0); pdllp(32'hD2, 2'b10, 1'b1);
      ptlp(32'hA1, 2'b00, 1'b0); ptlp(32'hA2, 2'b00, 1'b0);
      ptlp(32'hA3, 2'b00, 1'b0); ptlp(32'hA4, 2'b00, 1'b1);
      drive();
      run(12);
      ex(32'hD1, 2'b01, 1'b0); ex(32'hD2, 2'b01, 1'b1);
      ex(32'hA1, 2'b10, 1'b0); ex(32'hA2, 2'b10, 1'b0);
      ex(32'hA3, 2'b10, 1'b0); ex(32'hA4, 2'b10, 1'b1);
      cmp_stream("simul");
      if (out_cyc.size() >= 6)
         chk("simul_no_bubble", 64'(out_cyc[5] - out_cyc[0]), 64'(5));

      // Starvation limit: four DLLPs, then the waiting TLP, then the rest
      new_test();
      for (int i = 0; i < 6; i++) pdllp(32'hE0 + 32'(i), 2'b00, 1'b1);
      ptlp(32'hB0, 2'b00, 1'b1);
      drive();
      run(15);
      ex(32'hE0, 2'b01, 1'b1); ex(32'hE1, 2'b01, 1'b1); ex(32'hE2, 2'b01, 1'b1);
      ex(32'hE3, 2'b01, 1'b1); ex(32'hB0, 2'b10, 1'b1);
      ex(32'hE4, 2'b01, 1'b1); ex(32'hE5, 2'b01, 1'b1);
      cmp_stream("starve");

      // Link not active: DLLP only, TLP held off
      new_test();
      link = DL_INIT;
      ptlp(32'hC1, 2'b00, 1'b0); ptlp(32'hC2, 2'b00, 1'b1);
      pdllp(32'hF1, 2'b00, 1'b1);
      drive();
      run(10);
      chk("gate_out_count", 64'(out_q.size()), 64'(1));
      chk("gate_tlp_acc", 64'(tlp_acc), 64'(0));
      chk("gate_tlp_ready_seen", 64'(tlp_ready_seen), 64'(0));
      link = DL_ACTIVE;
      run(10);
      ex(32'hF1, 2'b01, 1'b1); ex(32'hC1, 2'b10, 1'b0); ex(32'hC2, 2'b10, 1'b1);
      cmp_stream("gate");

      // Link drops after beat 2 of a 5-beat TLP: packet still completes
      new_test();
      for (int i = 0; i < 5; i++) ptlp(32'h51 + 32'(i), 2'b00, (i == 4));
      drive();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tlp_acc >= 2) break;
      end
      link = DL_INACTIVE;
      run(12);
      for (int i = 0; i < 5; i++) ex(32'h51 + 32'(i), 2'b10, (i == 4));
      cmp_stream("link_drop");
      link = DL_ACTIVE;

      // Backpressure: two beats absorbed, then lossless release
      new_test();
      m_if.tready = 1'b0;
      for (int i = 0; i < 6; i++) ptlp(32'h61 + 32'(i), 2'b00, (i == 5));
      drive();
      run(10);
      chk("bp_absorbed", 64'(tlp_acc), 64'(2));
      chk("bp_out_held", 64'(out_q.size()), 64'(0));
      chk("bp_m_tvalid", 64'(m_if.tvalid), 64'(1));
      m_if.tready = 1'b1;
      run(15);
      chk("bp_total_acc", 64'(tlp_acc), 64'(6));
      for (int i = 0; i < 6; i++) ex(32'h61 + 32'(i), 2'b10, (i == 5));
      cmp_stream("bp");

      // Mid-packet reset after beat 2, then a clean DLLP
      new_test();
      for (int i = 0; i < 4; i++) ptlp(32'h71 + 32'(i), 2'b00, (i == 3));
      drive();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tlp_acc >= 2) break;
      end
      rst = 1'b1;
      tlp_q.delete();
      drive();
      tick();
      rst = 1'b0;
      chk("mrst_m_tvalid", 64'(m_if.tvalid), 64'(0));
      chk("mrst_state", 64'(dut.r_state), 64'(ST_IDLE));
      snap = out_q.size();
      pdllp(32'h81, 2'b00, 1'b1);
      drive();
      run(6);
      chk("mrst_after_count", 64'(out_q.size() - snap), 64'(1));
      if (out_q.size() > snap) begin
         chk("mrst_dllp_data", 64'(out_q[snap].d), 64'(32'h81));
         chk("mrst_dllp_user_last", 64'({out_q[snap].u, out_q[snap].l}), 64'({2'b01, 1'b1}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/axis_user_mux.md
Name: axis_user_mux

Overview:
- Transmit-side counterpart of the receive demux.
- Merges a TLP AXIS stream and a DLLP AXIS stream into one tagged AXIS stream toward the framing/PHY path.
- Arbitration is packet-atomic. DLLPs have priority, and a bounded-streak rule keeps TLPs from starving.
- A tuser type tag is stamped on every beat so downstream logic can tell the packet types apart.

Parameters:
- DATA_WIDTH, 32, data width of all streams.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 2, tuser width. Bit 1 = TLP tag, bit 0 = DLLP tag, must be >= 2.
- DLLP_BURST_MAX, 4, number of consecutive DLLP packets allowed while a TLP waits before the TLP is forced to win.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- link_status_i, in, pcie_dl_status_e, data link state.
- s_tlp_axis_tdata / tkeep / tvalid / tlast / tuser, in, DATA_WIDTH / KEEP_WIDTH / 1 / 1 / USER_WIDTH, TLP input.
- s_tlp_axis_tready, out, 1.
- s_dllp_axis_tdata / tkeep / tvalid / tlast / tuser, in, same widths, DLLP input.
- s_dllp_axis_tready, out, 1.
- m_axis_tdata / tkeep / tvalid / tlast / tuser, out, same widths, merged output.
- m_axis_tready, in, 1.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state = ST_IDLE, dllp_streak = 0, output register empty. As a result m_axis_tvalid = 0, s_tlp_axis_tready = 0 and s_dllp_axis_tready = 0.
- FSM states: ST_IDLE, ST_TLP, ST_DLLP.
- tlp_ok = s_tlp_axis_tvalid && (link_status_i == DL_ACTIVE).
- ST_IDLE grant rules:
  - Grant DLLP if s_dllp_axis_tvalid && !(tlp_ok && dllp_streak == DLLP_BURST_MAX).
  - Otherwise grant TLP if tlp_ok.
  - Otherwise stay in ST_IDLE.
  - The first beat passes in the grant cycle: the selected input's tready = reg_ready, and the next state is ST_DLLP or ST_TLP.
  - If that first beat is accepted with tlast set, the next state is ST_IDLE instead.
- ST_TLP / ST_DLLP:
  - Only the granted input sees tready = reg_ready. The other input's tready = 0.
  - Return to ST_IDLE when a beat is accepted (valid && ready) with tlast = 1.
- Packet atomicity: an open packet is never interrupted. If link_status_i leaves DL_ACTIVE mid-TLP, that TLP still completes. Only new TLP grants are blocked.
- DLLPs flow regardless of link_status_i; they are needed during DL_Init.
- dllp_streak counter:
  - Increments on each accepted DLLP tlast while s_tlp_axis_tvalid = 1, saturating at DLLP_BURST_MAX.
  - Clears on TLP grant.
  - Clears in any ST_IDLE cycle with s_tlp_axis_tvalid = 0.
- tuser stamping: output tuser = source tuser with bit 1 forced to (TLP ? 1 : 0) and bit 0 forced to (DLLP ? 1 : 0). Bits above 1 pass through unchanged.
- tdata, tkeep and tlast pass through unchanged.
- Output path:
  - A single skid-buffer register stage gives 1-cycle latency from input accept to m_axis_tvalid.
  - Full throughput is one beat per clock when m_axis_tready = 1.
  - reg_ready is the register's s_axis_tready.
  - With m_axis_tready held low, at most 2 beats are absorbed, then the granted input's tready drops.
- No input tvalid: stay in ST_IDLE and emit nothing. No bubble is inserted between back-to-back packets beyond the ST_IDLE grant cycle. That grant cycle itself carries a beat, so there is zero bubble.
- Reset mid-packet: the partial packet is dropped, the output register is flushed and the next grant is fresh.

Decomposition:
- pcie_datalink_pkg holds:
  - pcie_dl_status_e and SkidBuffer, both existing.
  - New localparams UserIsTlp = 1 and UserIsDllp = 0, shared with the demux.
  - A new typedef for the mux_st_e enum.
- Sub-module: reuse the existing axis_register with REG_TYPE = SkidBuffer and KEEP/LAST/USER enabled as the output stage.
- No new sub-module is needed.

Test Plan:
- TLP alone: link DL_ACTIVE, 3-beat TLP on tdata 0x11/0x22/0x33, m_axis_tready = 1 -> output beats 0x11/0x22/0x33 one cycle later, tuser[1:0] = 2'b10, tlast on the 3rd beat only.
- Simultaneous arrival: a 2-beat DLLP and a 4-beat TLP arrive in the same cycle -> DLLP emitted first with tuser[1:0] = 2'b01, then the TLP with no interleaving and no idle cycle between them.
- Starvation limit: DLLP_BURST_MAX = 4, 6 back-to-back 1-beat DLLPs plus a pending TLP -> order DLLP×4, TLP, DLLP×2.
- Link gating:
  - link_status_i != DL_ACTIVE with TLP and DLLP both valid -> only the DLLP is emitted and s_tlp_axis_tready stays 0.
  - Link drops after beat 2 of a 5-beat TLP -> all 5 beats are still emitted.
- Backpressure: m_axis_tready = 0 for 10 cycles during a 6-beat TLP -> exactly 2 beats accepted upstream, no data loss or duplication after release, order preserved.
- Mid-packet reset: rst_i for 1 cycle after beat 2 of a TLP -> next cycle m_axis_tvalid = 0 and state = ST_IDLE. A following DLLP is emitted cleanly with tuser[1:0] = 2'b01.
